mult_seq_nxn: RTL and testbench

//  Parametrised sequential NxN multiplier: radix-2 shift-add, one partial product per cycle.

---
 rtl/mult_pkg.sv | 21 ++
 rtl/mult_addshift_dp.sv | 64 ++++++
 rtl/mult_seq_nxn.sv | 153 +++++++++++++++
 tb/tb_mult_seq_nxn.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential NxN multiplier.
//   mult_state_e : controller state encoding (2 bits)
//   clog2        : ceiling log2, sizes the iteration counter
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mult_state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mult_addshift_dp.sv
// Radix-2 shift-add datapath: multiplicand, multiplier and accumulator
// registers plus the adder/shifter, driven by load/step strobes.
// Ports:
//   Clk        in   clock, posedge active
//   rst_n      in   synchronous active-low reset
//   load       in   capture ld_mcand/ld_mplr, clear accumulator
//   step       in   perform one add-then-shift iteration
//   ld_mcand   in   N    multiplicand magnitude
//   ld_mplr    in   N    multiplier magnitude
//   prod_next  out  2N   {acc,mplr} as it will be after this cycle's step
module mult_addshift_dp
   import mult_pkg::*;
#(
   parameter int N = 8
) (
   input  logic           Clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic           step,
   input  logic [N-1:0]   ld_mcand,
   input  logic [N-1:0]   ld_mplr,
   output logic [2*N-1:0] prod_next
);

   logic [N:0]   acc_q, acc_d;
   logic [N-1:0] mplr_q, mplr_d;
   logic [N-1:0] mcand_q, mcand_d;
   logic [N-1:0] addend;
   logic [N:0]   sum;

   // acc_q[N] is always zero after a shift, so the N+1 bit sum cannot overflow.
   always_comb begin
      addend    = mplr_q[0] ? mcand_q : '0;
      sum       = acc_q + {1'b0, addend};
      prod_next = {sum, mplr_q[N-1:1]};
   end

   always_comb begin
      acc_d   = acc_q;
      mplr_d  = mplr_q;
      mcand_d = mcand_q;
      if (load) begin
         acc_d   = '0;
         mplr_d  = ld_mplr;
         mcand_d = ld_mcand;
      end else if (step) begin
         acc_d  = {1'b0, sum[N:1]};
         mplr_d = {sum[0], mplr_q[N-1:1]};
      end
   end

   always_ff @(posedge Clk) begin
      if (!rst_n) begin
         acc_q   <= '0;
         mplr_q  <= '0;
         mcand_q <= '0;
      end else begin
         acc_q   <= acc_d;
         mplr_q  <= mplr_d;
         mcand_q <= mcand_d;
      end
   end

endmodule

// File: rtl/mult_seq_nxn.sv
// Sequential NxN multiplier, one partial product per cycle, with valid/ready
// handshakes on operand and product sides. Products are 2N bits, no truncation.
// Optional: define MULT_SIGNED_EN for two's complement operands and product.
// Ports:
//   Clk        in   clock, posedge active
//   rst_n      in   synchronous active-low reset
//   in_valid   in   operands a/b valid
//   in_ready   out  block can accept operands
//   a          in   N    multiplicand
//   b          in   N    multiplier
//   out_valid  out  product valid
//   out_ready  in   consumer accepts product
//   out        out  2N   product a*b (held until next product or reset)
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | one shift-add iteration per cycle, N cycles
// DONE  | product presented, waiting for out_ready
module mult_seq_nxn
   import mult_pkg::*;
#(
   parameter int N = 8
) (
   input  logic           Clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] out
);

   localparam int CNT_W = clog2(N + 1);

   mult_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2*N-1:0]  out_q, out_d;
   logic            out_valid_q, out_valid_d;
   logic            in_ready_q, in_ready_d;

   logic            load, step;
   logic [N-1:0]    a_mag, b_mag;
   logic [2*N-1:0]  prod_next, prod_fin;
   logic            opnd_zero;

`ifdef MULT_SIGNED_EN
   logic neg_q, neg_d;

   // |-2^(N-1)| = 2^(N-1) still fits in N unsigned bits.
   always_comb begin
      a_mag    = a[N-1] ? -a : a;
      b_mag    = b[N-1] ? -b : b;
      neg_d    = neg_q;
      if (load) neg_d = a[N-1] ^ b[N-1];
      prod_fin = neg_q ? -prod_next : prod_next;
   end

   always_ff @(posedge Clk) begin
      if (!rst_n) neg_q <= 1'b0;
      else        neg_q <= neg_d;
   end
`else
   always_comb begin
      a_mag    = a;
      b_mag    = b;
      prod_fin = prod_next;
   end
`endif

   assign opnd_zero = (a == '0) || (b == '0);

   mult_addshift_dp #(.N(N)) u_dp (
      .Clk       (Clk),
      .rst_n     (rst_n),
      .load      (load),
      .step      (step),
      .ld_mcand  (a_mag),
      .ld_mplr   (b_mag),
      .prod_next (prod_next)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;
      load        = 1'b0;
      step        = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               load       = 1'b1;
               cnt_d      = '0;
               in_ready_d = 1'b0;
               if (opnd_zero) begin
                  out_d       = '0;
                  out_valid_d = 1'b1;
                  state_d     = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            step  = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
            // The last step's result is taken combinationally so the product
            // lands in out_q on the same edge the FSM enters DONE.
            if (cnt_q == CNT_W'(N - 1)) begin
               out_d       = prod_fin;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out       = out_q;

endmodule

// File: tb/tb_mult_seq_nxn.sv
module tb_mult_seq_nxn;

   localparam int N = 8;

   logic          Clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  a;
   logic [N-1:0]  b;
   logic          out_valid;
   logic          out_ready;
   logic [2*N-1:0] out;

   int n_checks;
   int n_fail;

   mult_seq_nxn #(.N(N)) dut (
      .Clk       (Clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
`ifdef MULT_SIGNED_EN
      logic signed [15:0] sx, sy, p;
      sx = {{8{x[7]}}, x};
      sy = {{8{y[7]}}, y};
      p  = sx * sy;
      return p;
`else
      logic [15:0] ux, uy;
      ux = {8'd0, x};
      uy = {8'd0, y};
      return ux * uy;
`endif
   endfunction

   // Presents operands in the cycle after edge k; out_valid is expected to be
   // visible N+1 sampling points later (1 for the zero shortcut).
   task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [15:0] exp, input int lat, input logic rdy_early);
      int cyc;
      out_ready = rdy_early;
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      a = ia;
      b = ib;
      @(negedge Clk);
      in_valid = 1'b0;
      cyc = 1;
      while (out_valid !== 1'b1 && cyc < 40) begin
         @(negedge Clk);
         cyc++;
      end
      chk({tag, "_latency"}, 64'(cyc), 64'(lat));
      chk({tag, "_prod"}, 64'(out), 64'(exp));
      chk({tag, "_busy"}, 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      @(negedge Clk);
      chk({tag, "_vdrop"}, 64'(out_valid), 64'd0);
      chk({tag, "_hold"}, 64'(out), 64'(exp));
      out_ready = 1'b0;
   endtask

   initial begin
      logic [7:0] ra, rb;
      logic [7:0] edge_v [5];
      n_checks  = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      out_ready = 1'b0;
      edge_v[0] = 8'd0;   edge_v[1] = 8'd1;   edge_v[2] = 8'd127;
      edge_v[3] = 8'd128; edge_v[4] = 8'd255;

      repeat (3) @(negedge Clk);
      chk("rst_out", 64'(out), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      rst_n = 1'b1;
      @(negedge Clk);

      // out_ready already high: out_valid lasts one cycle
      run_op("t13x11", 8'd13, 8'd11, 16'h008F, 9, 1'b1);

`ifdef MULT_SIGNED_EN
      run_op("t255x255", 8'd255, 8'd255, 16'h0001, 9, 1'b0);
`else
      run_op("t255x255", 8'd255, 8'd255, 16'hFE01, 9, 1'b0);
`endif
      run_op("t1x1", 8'd1, 8'd1, 16'h0001, 9, 1'b0);
      run_op("t0x200", 8'd0, 8'd200, 16'h0000, 1, 1'b0);

      // stall in DONE with stray in_valid pulses in CALC and DONE
      begin
         int cyc;
         out_ready = 1'b0;
         in_valid = 1'b1;
         a = 8'd100;
         b = 8'd50;
         @(negedge Clk);
         in_valid = 1'b0;
         @(negedge Clk);
         in_valid = 1'b1;
         a = 8'd7;
         b = 8'd7;
         chk("stall_calc_in_ready", 64'(in_ready), 64'd0);
         @(negedge Clk);
         in_valid = 1'b0;
         cyc = 3;
         while (out_valid !== 1'b1 && cyc < 40) begin
            @(negedge Clk);
            cyc++;
         end
         chk("stall_latency", 64'(cyc), 64'd9);
         chk("stall_prod", 64'(out), 64'h1388);
         for (int i = 0; i < 5; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1;
            a = 8'd9;
            b = 8'd9;
            @(negedge Clk);
            chk("stall_out", 64'(out), 64'h1388);
            chk("stall_valid", 64'(out_valid), 64'd1);
         end
         in_valid = 1'b0;
         out_ready = 1'b1;
         @(negedge Clk);
         chk("stall_vdrop", 64'(out_valid), 64'd0);
         out_ready = 1'b0;
         repeat (3) @(negedge Clk);
         chk("stall_no_accept", 64'(out_valid), 64'd0);
         chk("stall_keep", 64'(out), 64'h1388);
         chk("stall_idle", 64'(in_ready), 64'd1);
      end

      // reset during CALC cycle 4
      out_ready = 1'b1;
      in_valid = 1'b1;
      a = 8'd13;
      b = 8'd11;
      @(negedge Clk);
      in_valid = 1'b0;
      repeat (3) @(negedge Clk);
      rst_n = 1'b0;
      @(negedge Clk);
      chk("midrst_out", 64'(out), 64'd0);
      chk("midrst_valid", 64'(out_valid), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      rst_n = 1'b1;
      repeat (12) @(negedge Clk);
      chk("midrst_discard", 64'(out_valid), 64'd0);
      run_op("t3x3", 8'd3, 8'd3, 16'h0009, 9, 1'b0);

`ifdef MULT_SIGNED_EN
      run_op("s_m3x5", 8'hFD, 8'd5, 16'hFFF1, 9, 1'b0);
      run_op("s_m128xm128", 8'h80, 8'h80, 16'h4000, 9, 1'b0);
      run_op("s_m128x127", 8'h80, 8'h7F, 16'hC080, 9, 1'b0);
`endif

      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < 5; j++) begin
            run_op("edge", edge_v[i], edge_v[j], model(edge_v[i], edge_v[j]),
                   (edge_v[i] == 8'd0 || edge_v[j] == 8'd0) ? 1 : 9, 1'b0);
         end
      end

      for (int i = 0; i < 250; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         run_op("rand", ra, rb, model(ra, rb),
                (ra == 8'd0 || rb == 8'd0) ? 1 : 9, i[0]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
